ripple_count_reader: RTL and testbench
======================================

# ripple_count_reader

Read-side companion to the 8-bit ripple counter: it samples the counter's raw, rippling `q` bus, filters out mid-ripple transient codes, and turns each settled change into a handshaked record. Each record carries the new count, the increment since the last record, and a wrap (epoch) count. It sits between the counter and any consumer that needs clean, ordered count values.

## Interface
- `WIDTH`, default 8: width of the counter bus and of `rd_count` and `rd_delta`.
- `STABLE_SAMPLES`, default 2: number of consecutive equal synchronized samples required before a value counts as settled; legal range 1..15.
- `EPOCH_W`, default 8: width of the wrap counter.
- `MAX_STEP`, default 1: largest legal per-record delta; anything larger flags a glitch.
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `q_in`, in, `WIDTH`: raw ripple-counter output; asynchronous to `clk` skew.
- `clear`, in, 1: synchronous soft clear with the same effect as `reset`.
- `rd_valid`, out, 1: a record is held.
- `rd_ready`, in, 1: the consumer accepts the record.
- `rd_count`, out, `WIDTH`: newest settled count.
- `rd_delta`, out, `WIDTH`: count increment covered by this record (modulo 2^`WIDTH`, coalesced, saturating).
- `rd_epoch`, out, `EPOCH_W`: number of wraps seen (modulo 2^`EPOCH_W`).
- `glitch_err`, out, 1: sticky flag.
- `overrun`, out, 1: sticky flag.

## Operation
- Capture: two-flop vector synchronizer gives `q_s2`; a third register `q_s3` holds the previous sample.
- Stability FSM, states SETTLING and SETTLED:
  - Any cycle with `q_s2` != `q_s3`: go to SETTLING and zero the stability counter.
  - Counter reaches `STABLE_SAMPLES` with `q_s2` == `q_s3`: go to SETTLED. The value is taken as settled only if it also differs from `last`; that case raises one `event` pulse.
- Event arithmetic:
  - `d` = `new` − `last`, modulo 2^`WIDTH`.
  - `wrap` = `new` < `last` (unsigned); `rd_epoch` increments on `wrap`.
  - `d` > `MAX_STEP` sets `glitch_err`, which stays set until `reset` or `clear`.
  - `last` <= `new`.
- Output FSM, states EMPTY and FULL:
  - EMPTY + event: load `rd_count` = `new`, `rd_delta` = `d`; go to FULL.
  - FULL, `rd_ready` = 1, no event: go to EMPTY.
  - FULL, `rd_ready` = 1, event in the same cycle: the fresh record replaces the accepted one (`rd_delta` = `d` only); stay FULL.
  - FULL, `rd_ready` = 0, event: coalesce. `rd_count` = `new`; `rd_delta` += `d`, saturating at all-ones; set sticky `overrun`.
- Reset and clear values, for all outputs and internal state:
  - `rd_valid`, `rd_count`, `rd_delta`, `rd_epoch`, `glitch_err`, `overrun` all 0.
  - `last` = 0, `q_s2` = 0, `q_s3` = 0.
  - Both FSMs: SETTLING and EMPTY.
- Reset or clear while FULL drops the held record; nothing is replayed afterwards.
- Equal values across a reset boundary produce no event, because `last` is 0 and the counter also resets to 0.

## Timing
- Latency: `q_in` changes and is held; `rd_valid` rises on rising edge 3 + `STABLE_SAMPLES` after the change. With defaults that is edge 5.
- Handshake:
  - Transfer happens on a rising edge where `rd_valid` and `rd_ready` are both 1.
  - `rd_count`, `rd_delta`, `rd_epoch` stay stable while `rd_valid` = 1 and `rd_ready` = 0, except for coalescing.
  - `rd_ready` may be held high; with no new events, `rd_valid` then lasts one cycle per event.
- Throughput: at most one event per `STABLE_SAMPLES` + 1 cycles. Faster input changes never settle and are dropped, not queued.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `ripple_reader_pkg`:
  - State enums `stab_state_t` {SETTLING, SETTLED} and `out_state_t` {EMPTY, FULL}.
  - Default parameter constants.
  - A saturating-add helper function.
- Sub-module `count_sync`: parameterized `WIDTH` two-flop synchronizer with asynchronous reset to 0.
- The stability FSM, event arithmetic and output FSM live in the top level.

## Test plan
- Reset and step: `reset` pulse, then `q_in` 0→1 held → `rd_valid` on edge 5. Record: `rd_count` = 1, `rd_delta` = 1, `rd_epoch` = 0, no flags.
- Transient rejection: `q_in` 1→3 for 1 cycle, then →2 and held → single record with `rd_count` = 2, `rd_delta` = 1; no record for 3.
- Wrap: `q_in` stepped 254→255→0 with `rd_ready` = 1 → records carry `rd_delta` = 1 each; after the 0 record `rd_epoch` = 1 and `glitch_err` = 0.
- Backpressure coalescing: `rd_ready` = 0 while `q_in` steps 5→6→7→8, `rd_ready` = 1 after 20 cycles → one record with `rd_count` = 8, `rd_delta` = 3; `overrun` = 1.
- Glitch: `q_in` 8→40 held → `rd_delta` = 32 and `glitch_err` = 1; `glitch_err` stays set until `clear`, which returns all outputs to 0.
- Mid-operation reset: assert `reset` while FULL with `rd_ready` = 0 → `rd_valid` falls asynchronously, before the next edge; no record appears after reset while `q_in` stays 0.

Source files
------------

// File: rtl/ripple_reader_pkg.sv
// Shared types, default parameters and helpers for the ripple counter reader.
package ripple_reader_pkg;

   // Stability tracker states: waiting for the bus to stop rippling, or settled.
   typedef enum logic {
      SETTLING = 1'b0,
      SETTLED  = 1'b1
   } stab_state_t;

   // Output record holder states.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   localparam int DEF_WIDTH          = 8;
   localparam int DEF_STABLE_SAMPLES = 2;
   localparam int DEF_EPOCH_W        = 8;
   localparam int DEF_MAX_STEP       = 1;

   // Unsigned add of two w-bit values (w <= 31), clamped to all-ones of w bits.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [5:0]  w);
      logic [32:0] sum_v;
      logic [32:0] lim_v;
      sum_v = {1'b0, a} + {1'b0, b};
      lim_v = (33'd1 << w) - 33'd1;
      if (sum_v > lim_v) begin
         sat_add = lim_v[31:0];
      end else begin
         sat_add = sum_v[31:0];
      end
   endfunction

endpackage

// File: rtl/count_sync.sv
// Two-flop vector synchronizer for the raw ripple counter bus.
// Individual bits may resolve on different cycles while the bus ripples;
// the stability filter downstream is what removes those mixed codes.
module count_sync
   import ripple_reader_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // Two-stage capture of the asynchronous bus; soft clear zeroes both stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_r <= {WIDTH{1'b0}};
         sync_r <= {WIDTH{1'b0}};
      end else if (clear) begin
         meta_r <= {WIDTH{1'b0}};
         sync_r <= {WIDTH{1'b0}};
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/ripple_count_reader.sv
// Ripple counter reader: synchronizes the raw count bus, waits for it to hold
// still, and emits one handshaked record (count, delta, epoch) per settled change.
module ripple_count_reader
   import ripple_reader_pkg::*;
#(
   parameter int WIDTH          = DEF_WIDTH,
   parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
   parameter int EPOCH_W        = DEF_EPOCH_W,
   parameter int MAX_STEP       = DEF_MAX_STEP
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   q_in,
   input  logic               clear,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [WIDTH-1:0]   rd_count,
   output logic [WIDTH-1:0]   rd_delta,
   output logic [EPOCH_W-1:0] rd_epoch,
   output logic               glitch_err,
   output logic               overrun
);

   localparam logic [3:0]       STAB_TGT   = 4'(STABLE_SAMPLES);
   localparam logic [WIDTH-1:0] MAX_STEP_V = WIDTH'(MAX_STEP);

   // ------------------------------------------------------------------
   // Capture
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] q_s2_s;
   logic [WIDTH-1:0] q_s3_r;

   count_sync #(.WIDTH(WIDTH)) u_sync (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .d     (q_in),
      .q     (q_s2_s)
   );

   // ------------------------------------------------------------------
   // Stability FSM
   // ------------------------------------------------------------------
   stab_state_t stab_state_r;
   stab_state_t stab_next_s;
   logic [3:0]  stab_cnt_r;
   logic [3:0]  stab_cnt_next_s;
   logic [3:0]  stab_cnt_inc_s;
   logic        settle_s;
   logic        event_s;

   assign stab_cnt_inc_s = stab_cnt_r + 4'd1;

   // Next-state for the stability tracker; settle_s marks the cycle the
   // required number of equal samples is reached.
   always_comb begin
      stab_next_s     = stab_state_r;
      stab_cnt_next_s = stab_cnt_r;
      settle_s        = 1'b0;
      if (q_s2_s != q_s3_r) begin
         stab_next_s     = SETTLING;
         stab_cnt_next_s = 4'd0;
      end else begin
         case (stab_state_r)
            SETTLING: begin
               if (stab_cnt_inc_s == STAB_TGT) begin
                  stab_next_s     = SETTLED;
                  stab_cnt_next_s = stab_cnt_inc_s;
                  settle_s        = 1'b1;
               end else begin
                  stab_cnt_next_s = stab_cnt_inc_s;
               end
            end
            SETTLED: begin
               stab_next_s     = SETTLED;
               stab_cnt_next_s = stab_cnt_r;
            end
            default: begin
               stab_next_s     = SETTLING;
               stab_cnt_next_s = 4'd0;
            end
         endcase
      end
   end

   // Previous-sample register and stability state/counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_s3_r       <= {WIDTH{1'b0}};
         stab_state_r <= SETTLING;
         stab_cnt_r   <= 4'd0;
      end else if (clear) begin
         q_s3_r       <= {WIDTH{1'b0}};
         stab_state_r <= SETTLING;
         stab_cnt_r   <= 4'd0;
      end else begin
         q_s3_r       <= q_s2_s;
         stab_state_r <= stab_next_s;
         stab_cnt_r   <= stab_cnt_next_s;
      end
   end

   // ------------------------------------------------------------------
   // Event arithmetic
   // ------------------------------------------------------------------
   logic [WIDTH-1:0]   last_r;
   logic [EPOCH_W-1:0] epoch_r;
   logic               glitch_r;
   logic [WIDTH-1:0]   d_s;
   logic               wrap_s;
   logic               step_bad_s;

   // A settled value only counts as an event when it differs from the last one.
   assign event_s    = settle_s && (q_s2_s != last_r);
   assign d_s        = q_s2_s - last_r;
   assign wrap_s     = (q_s2_s < last_r);
   assign step_bad_s = (d_s > MAX_STEP_V);

   // Last accepted value, wrap counter and sticky glitch flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_r   <= {WIDTH{1'b0}};
         epoch_r  <= {EPOCH_W{1'b0}};
         glitch_r <= 1'b0;
      end else if (clear) begin
         last_r   <= {WIDTH{1'b0}};
         epoch_r  <= {EPOCH_W{1'b0}};
         glitch_r <= 1'b0;
      end else if (event_s) begin
         last_r <= q_s2_s;
         if (wrap_s) begin
            epoch_r <= epoch_r + {{(EPOCH_W-1){1'b0}}, 1'b1};
         end else begin
            epoch_r <= epoch_r;
         end
         if (step_bad_s) begin
            glitch_r <= 1'b1;
         end else begin
            glitch_r <= glitch_r;
         end
      end else begin
         last_r   <= last_r;
         epoch_r  <= epoch_r;
         glitch_r <= glitch_r;
      end
   end

   // ------------------------------------------------------------------
   // Output FSM
   // ------------------------------------------------------------------
   out_state_t       out_state_r;
   out_state_t       out_next_s;
   logic [WIDTH-1:0] rd_count_r;
   logic [WIDTH-1:0] rd_count_next_s;
   logic [WIDTH-1:0] rd_delta_r;
   logic [WIDTH-1:0] rd_delta_next_s;
   logic [WIDTH-1:0] delta_sum_s;
   logic             overrun_r;
   logic             overrun_next_s;

   // Coalesced increment, clamped so a long backpressure stall cannot wrap it.
   assign delta_sum_s = WIDTH'(sat_add(32'(rd_delta_r), 32'(d_s), 6'(WIDTH)));

   // Record holder: load, hand off, replace on simultaneous accept, or coalesce.
   always_comb begin
      out_next_s      = out_state_r;
      rd_count_next_s = rd_count_r;
      rd_delta_next_s = rd_delta_r;
      overrun_next_s  = overrun_r;
      case (out_state_r)
         EMPTY: begin
            if (event_s) begin
               out_next_s      = FULL;
               rd_count_next_s = q_s2_s;
               rd_delta_next_s = d_s;
            end else begin
               out_next_s = EMPTY;
            end
         end
         FULL: begin
            if (rd_ready) begin
               if (event_s) begin
                  out_next_s      = FULL;
                  rd_count_next_s = q_s2_s;
                  rd_delta_next_s = d_s;
               end else begin
                  out_next_s = EMPTY;
               end
            end else begin
               if (event_s) begin
                  rd_count_next_s = q_s2_s;
                  rd_delta_next_s = delta_sum_s;
                  overrun_next_s  = 1'b1;
               end else begin
                  out_next_s = FULL;
               end
            end
         end
         default: begin
            out_next_s = EMPTY;
         end
      endcase
   end

   // Output record registers; all outputs come straight from flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_state_r <= EMPTY;
         rd_count_r  <= {WIDTH{1'b0}};
         rd_delta_r  <= {WIDTH{1'b0}};
         overrun_r   <= 1'b0;
      end else if (clear) begin
         out_state_r <= EMPTY;
         rd_count_r  <= {WIDTH{1'b0}};
         rd_delta_r  <= {WIDTH{1'b0}};
         overrun_r   <= 1'b0;
      end else begin
         out_state_r <= out_next_s;
         rd_count_r  <= rd_count_next_s;
         rd_delta_r  <= rd_delta_next_s;
         overrun_r   <= overrun_next_s;
      end
   end

   assign rd_valid   = (out_state_r == FULL);
   assign rd_count   = rd_count_r;
   assign rd_delta   = rd_delta_r;
   assign rd_epoch   = epoch_r;
   assign glitch_err = glitch_r;
   assign overrun    = overrun_r;

endmodule

// File: tb/tb_ripple_count_reader.sv
// Scoreboard bench for ripple_count_reader with default parameters.
module tb_ripple_count_reader;

   logic       clk;
   logic       reset;
   logic [7:0] q_in;
   logic       clear;
   logic       rd_valid;
   logic       rd_ready;
   logic [7:0] rd_count;
   logic [7:0] rd_delta;
   logic [7:0] rd_epoch;
   logic       glitch_err;
   logic       overrun;

   ripple_count_reader dut (
      .clk        (clk),
      .reset      (reset),
      .q_in       (q_in),
      .clear      (clear),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_count   (rd_count),
      .rd_delta   (rd_delta),
      .rd_epoch   (rd_epoch),
      .glitch_err (glitch_err),
      .overrun    (overrun)
   );

   typedef struct packed {
      logic [7:0] cnt;
      logic [7:0] dl;
      logic [7:0] ep;
   } rec_t;

   rec_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   // Reference model state.
   logic [7:0] m_last    = 8'd0;
   logic [7:0] m_epoch   = 8'd0;
   logic       m_glitch  = 1'b0;
   logic       m_overrun = 1'b0;
   logic       p_valid   = 1'b0;
   logic [7:0] p_count   = 8'd0;
   logic [7:0] p_delta   = 8'd0;
   logic [7:0] p_epoch   = 8'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic model_reset();
      m_last    = 8'd0;
      m_epoch   = 8'd0;
      m_glitch  = 1'b0;
      m_overrun = 1'b0;
      p_valid   = 1'b0;
   endtask

   // Drive a new settled value, update the model, and either queue the
   // expected record or fold it into a pending (backpressured) record.
   task automatic set_val(input logic [7:0] v, input bit hold);
      logic [7:0] d;
      logic [8:0] s;
      d = v - m_last;
      if (v < m_last) m_epoch = m_epoch + 8'd1;
      if (d > 8'd1) m_glitch = 1'b1;
      m_last = v;
      if (!hold) begin
         sb_q.push_back(rec_t'{v, d, m_epoch});
      end else begin
         if (p_valid) begin
            s = {1'b0, p_delta} + {1'b0, d};
            p_delta = s[8] ? 8'hFF : s[7:0];
            m_overrun = 1'b1;
         end else begin
            p_delta = d;
         end
         p_count = v;
         p_epoch = m_epoch;
         p_valid = 1'b1;
      end
      q_in = v;
      repeat (6) step();
   endtask

   // Scoreboard monitor: every transfer must match the oldest expected record.
   always @(negedge clk) begin
      rec_t r;
      if (mon_en && !reset && rd_valid && rd_ready) begin
         chk("rec_expected", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            chk("rec_count", 32'(rd_count), 32'(r.cnt));
            chk("rec_delta", 32'(rd_delta), 32'(r.dl));
            chk("rec_epoch", 32'(rd_epoch), 32'(r.ep));
         end
      end
   end

   initial begin
      reset    = 1'b1;
      clear    = 1'b0;
      q_in     = 8'd0;
      rd_ready = 1'b0;
      repeat (3) step();
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_count", 32'(rd_count), 32'd0);
      chk("rst_delta", 32'(rd_delta), 32'd0);
      chk("rst_epoch", 32'(rd_epoch), 32'd0);
      chk("rst_flags", {30'd0, glitch_err, overrun}, 32'd0);
      reset = 1'b0;
      mon_en = 1'b1;
      repeat (6) step();
      chk("idle_no_rec", 32'(rd_valid), 32'd0);

      // Step 0->1 held; record must appear exactly on edge 5.
      m_last = 8'd1;
      sb_q.push_back(rec_t'{8'd1, 8'd1, 8'd0});
      q_in = 8'd1;
      repeat (4) step();
      chk("lat_edge4", 32'(rd_valid), 32'd0);
      step();
      chk("lat_edge5", 32'(rd_valid), 32'd1);
      chk("step_flags", {30'd0, glitch_err, overrun}, 32'd0);
      rd_ready = 1'b1;
      repeat (3) step();
      chk("step_drained", 32'(rd_valid), 32'd0);

      // One-cycle transient 3 must be dropped; only 2 is reported.
      q_in = 8'd3;
      step();
      set_val(8'd2, 1'b0);
      repeat (4) step();
      chk("transient_sb", 32'(sb_q.size()), 32'd0);

      // Unit steps up to 255 and wrap to 0.
      for (int v = 3; v <= 255; v++) set_val(8'(v), 1'b0);
      set_val(8'd0, 1'b0);
      chk("wrap_epoch", 32'(rd_epoch), 32'(m_epoch));
      chk("wrap_glitch", 32'(glitch_err), 32'(m_glitch));

      // Backpressure: 6, 7, 8 coalesce into one record.
      for (int v = 1; v <= 5; v++) set_val(8'(v), 1'b0);
      rd_ready = 1'b0;
      set_val(8'd6, 1'b1);
      set_val(8'd7, 1'b1);
      set_val(8'd8, 1'b1);
      repeat (20) step();
      chk("bp_valid", 32'(rd_valid), 32'd1);
      chk("bp_count", 32'(rd_count), 32'(p_count));
      chk("bp_delta", 32'(rd_delta), 32'(p_delta));
      chk("bp_overrun", 32'(overrun), 32'(m_overrun));
      sb_q.push_back(rec_t'{p_count, p_delta, p_epoch});
      p_valid = 1'b0;
      rd_ready = 1'b1;
      repeat (4) step();
      chk("bp_drained", 32'(sb_q.size()), 32'd0);

      // Large jump flags a glitch, which is sticky until clear.
      set_val(8'd40, 1'b0);
      chk("glitch_set", 32'(glitch_err), 32'(m_glitch));
      repeat (5) step();
      chk("glitch_sticky", 32'(glitch_err), 32'd1);
      clear = 1'b1;
      q_in = 8'd0;
      step();
      clear = 1'b0;
      model_reset();
      chk("clr_valid", 32'(rd_valid), 32'd0);
      chk("clr_count", 32'(rd_count), 32'd0);
      chk("clr_delta", 32'(rd_delta), 32'd0);
      chk("clr_epoch", 32'(rd_epoch), 32'd0);
      chk("clr_flags", {30'd0, glitch_err, overrun}, 32'd0);
      repeat (10) step();
      chk("clr_no_rec", 32'(rd_valid), 32'd0);

      // Reset while FULL: valid must drop before the next edge, nothing replays.
      rd_ready = 1'b0;
      q_in = 8'd1;
      repeat (6) step();
      chk("mr_full", 32'(rd_valid), 32'd1);
      reset = 1'b1;
      q_in = 8'd0;
      #1;
      chk("mr_async_valid", 32'(rd_valid), 32'd0);
      chk("mr_async_count", 32'(rd_count), 32'd0);
      step();
      reset = 1'b0;
      model_reset();
      rd_ready = 1'b1;
      repeat (12) step();
      chk("mr_no_rec", 32'(rd_valid), 32'd0);
      chk("final_sb", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
